// File: rtl/rd_pkt_pkg.sv
// Shared types and constants for the frame read packetizer.
package rd_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT_RDY,
    ST_STREAM,
    ST_DRAIN
  } rd_state_e;

  localparam int RAM_WIDTH       = 128;
  localparam int RD_LATENCY      = 2;
  localparam int DEF_FRAME_BEATS = 388800;
  localparam int DEF_PKT_BEATS   = 16;
  localparam int ISSUE_W         = 20;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a push on full succeeds only with a same-cycle pop.
module sync_fifo_fwft
  import rd_pkt_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rstn_i && do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rd_pkt_gen.sv
// Frame read sequencer: issues beat reads to an upstream buffer with fixed latency,
// buffers returned beats in a skid FIFO and emits them as packetized stream.
module rd_pkt_gen
  import rd_pkt_pkg::*;
#(
  parameter int FRAME_BEATS = DEF_FRAME_BEATS,
  parameter int PKT_BEATS   = DEF_PKT_BEATS,
  parameter int SYNC_CYC    = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 vout_clk,
  input  logic                 vout_rstn,
  input  logic                 i_start,
  output logic                 o_rd_fsync,
  output logic                 o_rd_en,
  input  logic                 i_vout_de,
  input  logic [RAM_WIDTH-1:0] i_vout_data,
  input  logic                 i_data_ready,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [RAM_WIDTH-1:0] m_tdata,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = CW + 1;
  localparam int SW = $clog2(SYNC_CYC) + 1;
  localparam int PW = $clog2(PKT_BEATS) + 1;
  localparam logic [ISSUE_W-1:0] FRAME_N    = ISSUE_W'(FRAME_BEATS);
  localparam logic [ISSUE_W-1:0] FRAME_LAST = ISSUE_W'(FRAME_BEATS - 1);

  rd_state_e             state_q, state_d;
  logic [SW-1:0]         sync_cnt_q, sync_cnt_d;
  logic [ISSUE_W-1:0]    issued_q, issued_d;
  logic [ISSUE_W-1:0]    beats_q, beats_d;
  logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [RD_LATENCY-1:0] inflight_q;
  logic                  ovf_q, done_q, done_d;
  logic                  rd_en, pop, can_issue, pkt_last, frame_last;
  logic [RW-1:0]         reserve;

  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_cnt;

  sync_fifo_fwft #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (vout_clk),
    .rstn_i  (vout_rstn),
    .push_i  (i_vout_de),
    .din_i   (i_vout_data),
    .pop_i   (pop),
    .dout_o  (m_tdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Reads still in the latency pipe already own a FIFO slot.
  assign reserve   = RW'(fifo_cnt) + RW'($countones(inflight_q)) + RW'(1);
  assign can_issue = (reserve <= RW'(FIFO_DEPTH));

  assign m_tvalid   = !fifo_empty;
  assign pop        = m_tvalid && m_tready;
  assign pkt_last   = (pkt_cnt_q == PW'(PKT_BEATS - 1));
  assign frame_last = (beats_q == FRAME_LAST);
  assign m_tlast    = m_tvalid && (pkt_last || frame_last);
  assign m_tuser    = m_tvalid && (beats_q == '0);

  assign o_rd_fsync   = (state_q == ST_SYNC);
  assign o_rd_en      = rd_en;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = done_q;
  assign o_ovf        = ovf_q;

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    issued_d   = issued_q;
    rd_en      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
          issued_d   = '0;
        end
      end
      ST_SYNC: begin
        if (sync_cnt_q == SW'(SYNC_CYC - 1)) state_d = ST_WAIT_RDY;
        else                                 sync_cnt_d = sync_cnt_q + 1'b1;
      end
      ST_WAIT_RDY: begin
        if (i_data_ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en = i_data_ready && (issued_q < FRAME_N) && can_issue;
        if (rd_en) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == FRAME_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0 && fifo_empty && beats_q == FRAME_N) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beats_d   = beats_q;
    pkt_cnt_d = pkt_cnt_q;
    if (state_q == ST_IDLE && i_start) begin
      beats_d   = '0;
      pkt_cnt_d = '0;
    end else if (pop) begin
      beats_d   = beats_q + 1'b1;
      pkt_cnt_d = (pkt_last || frame_last) ? '0 : pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge vout_clk) begin
    if (!vout_rstn) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      pkt_cnt_q  <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      pkt_cnt_q  <= pkt_cnt_d;
      inflight_q <= {inflight_q[RD_LATENCY-2:0], rd_en};
      done_q     <= done_d;
      if (i_vout_de && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: doc/rd_pkt_gen.md
RD_PKT_GEN -- requirements
Module: rd_pkt_gen

Interface
REQ-001 SHALL have parameter FRAME_BEATS, default 388800; 128-bit beats per frame (1920x1080x24/128).
REQ-002 SHALL have parameter PKT_BEATS, default 16; beats per output packet (256 B payload).
REQ-003 SHALL have parameter SYNC_CYC, default 8; width of the o_rd_fsync pulse in cycles.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8; skid FIFO entries, power of two, at least 4.
REQ-005 SHALL have port vout_clk, in, 1; the single clock. Reset is synchronous and active-low.
REQ-006 SHALL have port vout_rstn, in, 1; synchronous active-low reset.
REQ-007 SHALL have port i_start, in, 1; one-cycle frame transfer request.
REQ-008 SHALL have port o_rd_fsync, out, 1; frame sync to the upstream read buffer.
REQ-009 SHALL have port o_rd_en, out, 1; beat read strobe to the upstream read buffer.
REQ-010 SHALL have port i_vout_de, in, 1; upstream data valid, arriving exactly 2 cycles after o_rd_en.
REQ-011 SHALL have port i_vout_data, in, 128; upstream beat data.
REQ-012 SHALL have port i_data_ready, in, 1; upstream fill-level ready (hysteretic level).
REQ-013 SHALL have port m_tvalid, out, 1; m_tready, in, 1; m_tdata, out, 128; these form the output stream.
REQ-014 SHALL have port m_tlast, out, 1 (packet end) and m_tuser, out, 1 (first beat of frame).
REQ-015 SHALL have port o_busy, out, 1; o_frame_done, out, 1 (one-cycle pulse); o_ovf, out, 1 (sticky FIFO overflow).

Function
REQ-016 SHALL implement FSM states IDLE, SYNC, WAIT_RDY, STREAM, DRAIN.
REQ-017 In IDLE, i_start SHALL move the FSM to SYNC; i_start in any other state SHALL be ignored.
REQ-018 In SYNC, o_rd_fsync SHALL be high for exactly SYNC_CYC cycles, then the FSM SHALL go to WAIT_RDY. o_rd_fsync SHALL be low in all other states.
REQ-019 WAIT_RDY SHALL go to STREAM on the first cycle i_data_ready=1.
REQ-020 In STREAM, o_rd_en SHALL be 1 iff all of the following hold: i_data_ready=1; issued < FRAME_BEATS; fifo_count + inflight + 1 <= FIFO_DEPTH. Here inflight is the number of o_rd_en pulses issued in the last 2 cycles.
REQ-021 The issue counter SHALL be 20 bits and SHALL increment per o_rd_en. When it reaches FRAME_BEATS, the FSM SHALL go to DRAIN.
REQ-022 Each cycle with i_vout_de=1 SHALL push i_vout_data into the FIFO, regardless of FSM state. A push when the FIFO is full SHALL drop the data and set o_ovf.
REQ-023 m_tvalid SHALL equal FIFO not-empty, and m_tdata SHALL equal the FIFO head (first-word-fall-through). A pop SHALL occur iff m_tvalid && m_tready.
REQ-024 A simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-025 The output beat counter SHALL count popped beats. m_tuser SHALL be 1 on beat 0 of the frame.
REQ-026 m_tlast SHALL be 1 on every beat where (beat index + 1) mod PKT_BEATS = 0, and on beat FRAME_BEATS-1.
REQ-027 DRAIN SHALL return to IDLE when inflight=0, the FIFO is empty, and FRAME_BEATS beats have been popped. o_frame_done SHALL pulse for 1 cycle on that transition.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 i_data_ready falling mid-STREAM SHALL stop o_rd_en the same cycle. Beats already in flight SHALL still be accepted.
REQ-030 m_tvalid, once high, SHALL stay high with m_tdata stable until m_tready=1.

Reset
REQ-031 While vout_rstn=0 at a vout_clk edge, the following SHALL be cleared: FSM state (to IDLE), counters, the inflight pipe, FIFO pointers, and o_ovf.
REQ-032 All outputs SHALL reset to 0, except m_tdata, which is don't-care while m_tvalid=0.
REQ-033 Reset mid-frame SHALL abort the transfer with no o_frame_done pulse. Data arriving on i_vout_de during reset SHALL be discarded.

Structure
REQ-034 Package rd_pkt_pkg SHALL hold: the FSM state encoding, RAM_WIDTH=128, RD_LATENCY=2, and the default FRAME_BEATS/PKT_BEATS.
REQ-035 The FIFO SHALL be the sub-module sync_fifo_fwft (parameterised width and depth; outputs full, empty, and count).

Verification
REQ-036 FRAME_BEATS=40, PKT_BEATS=16, m_tready=1, i_data_ready=1 -> 40 beats out; m_tlast on beats 15, 31, 39; m_tuser on beat 0 only; o_frame_done pulses once.
REQ-037 Same setup with m_tready held 0 for 20 cycles mid-frame -> o_rd_en stops once FIFO_DEPTH=8 beats are reserved; no data loss; o_ovf stays 0.
REQ-038 i_data_ready toggling 0/1 every 5 cycles -> o_rd_en only while ready; 40 in-order beats out (data = beat index).
REQ-039 i_start pulsed again during STREAM -> ignored; exactly one frame out.
REQ-040 vout_rstn asserted at beat 10 -> all outputs 0 next cycle; no o_frame_done. After release, a new i_start produces o_rd_fsync high for 8 cycles.
REQ-041 Forced extra i_vout_de pulses into a full FIFO -> o_ovf=1, and it stays set until reset.
